regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side front end of the 32x32 register file. Accepts results from the ALU and LSU
//  over valid/ready, queues them in a small in-order FIFO, and drives the regfile write
//  port (rdaddr/data/enable) one entry per cycle. Also supplies a youngest-first bypass
//  lookup so the read side sees queued results not yet written into the regfile.
// PARAMETERS
//  XLEN   32  data width of every result and write-port value
//  AW     5   register address width (32 architectural registers)
//  DEPTH  2   FIFO entries; power of two, >=2
// PORTS
//  clk         in   1     single clock; all state updates on posedge
//  reset       in   1     asynchronous, active-low; clears all state
//  alu_valid   in   1     ALU result offered
//  alu_ready   out  1     ALU result accepted when alu_valid&alu_ready
//  alu_rd      in   AW    ALU destination register
//  alu_data    in   XLEN  ALU result
//  lsu_valid   in   1     load result offered
//  lsu_ready   out  1     load result accepted when lsu_valid&lsu_ready
//  lsu_rd      in   AW    load destination register
//  lsu_data    in   XLEN  load data
//  wr_stall    in   1     regfile write port unavailable this cycle; hold the head entry
//  rdaddr      out  AW    regfile write address (head entry)
//  data        out  XLEN  regfile write data (head entry)
//  enable      out  1     regfile write strobe
//  rs1addr     in   AW    bypass lookup address 1
//  rs2addr     in   AW    bypass lookup address 2
//  fwd_a_hit   out  1     rs1addr matches a queued entry
//  fwd_a       out  XLEN  youngest matching queued data for rs1addr, else 0
//  fwd_b_hit   out  1     rs2addr matches a queued entry
//  fwd_b       out  XLEN  youngest matching queued data for rs2addr, else 0
//  count       out  $clog2(DEPTH+1)  number of queued entries
// BEHAVIOUR
//  - Reset (async, reset=0): wr_ptr, rd_ptr, count <= 0; enable=0, rdaddr=0, data=0, fwd_*=0;
//    FIFO contents are don't-care. Reset mid-operation discards every queued entry.
//  - Acceptance: ALU has fixed priority. alu_ready = (count<DEPTH);
//    lsu_ready = (count<DEPTH) & ~alu_valid. At most one accept per cycle.
//  - Accepted results with rd==0 complete the handshake but are NOT enqueued (x0 stays 0).
//  - Enqueue: entry {rd,data} written at wr_ptr; wr_ptr wraps modulo DEPTH.
//  - Drain: enable = (count!=0) & ~wr_stall; rdaddr/data = head entry (combinational from
//    rd_ptr; 0 when empty). On enable, rd_ptr advances (wraps modulo DEPTH). The regfile
//    captures the write on the same posedge, so latency accept->regfile update = 1 cycle
//    when the FIFO is empty and wr_stall=0.
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//  - Full: ready deasserts based on the registered count only; a same-cycle dequeue does
//    not reopen ready (no full-pass-through).
//  - Bypass: combinational. For each rsXaddr!=0, scan valid entries youngest to oldest;
//    first match gives hit=1 and its data. rsXaddr==0 or no match -> hit=0, value 0.
//    The head entry being written this cycle still counts as a hit.
//  - count never exceeds DEPTH and never underflows; ready outputs are independent of
//    current-cycle lsu/alu data and of wr_stall.
// TESTING
//  1 Reset: assert reset=0 mid-stream with count=2 -> count=0, enable=0, fwd_*_hit=0
//    immediately; after release, first ALU result is the first write.
//  2 ALU rd=5 data=0xDEADBEEF, wr_stall=0 -> next cycle enable=1, rdaddr=5,
//    data=0xDEADBEEF; following cycle enable=0, count=0.
//  3 Both valid same cycle (ALU rd=3 0x11, LSU rd=4 0x22) -> alu_ready=1, lsu_ready=0;
//    LSU accepted next cycle; writes appear in order r3 then r4.
//  4 wr_stall=1, enqueue r7=0xA then r7=0xB -> count=2, both readies 0, rs1addr=7 gives
//    fwd_a_hit=1 fwd_a=0xB; release stall -> writes 0xA then 0xB.
//  5 ALU rd=0 data=0xFFFF -> handshake completes, count stays 0, enable never asserts;
//    rs2addr=0 -> fwd_b_hit=0, fwd_b=0.
//  6 Sustained back-to-back ALU stream, 20 results, wr_stall=0 -> one write per cycle,
//    alu_ready stays 1, count<=1, pointer wrap across DEPTH boundary loses no entries.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end of the register file.
// Accepts ALU/LSU results over valid/ready (the ALU has priority) and queues them in
// a small in-order FIFO. It drives the regfile write port from the head entry and
// provides a youngest-first bypass lookup of the queued entries for two read addresses.
// Ports:
//   clk, reset (async, active-low)
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   load result handshake
//   wr_stall                              regfile write port busy; hold head entry
//   rdaddr/data/enable                    regfile write port
//   rs1addr/rs2addr -> fwd_{a,b}_hit, fwd_{a,b}  bypass lookups
//   count                                 number of queued entries
module regfile_writeback #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [AW-1:0]                alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [AW-1:0]                lsu_rd,
    input  logic [XLEN-1:0]              lsu_data,
    input  logic                         wr_stall,
    output logic [AW-1:0]                rdaddr,
    output logic [XLEN-1:0]              data,
    output logic                         enable,
    input  logic [AW-1:0]                rs1addr,
    input  logic [AW-1:0]                rs2addr,
    output logic                         fwd_a_hit,
    output logic [XLEN-1:0]              fwd_a,
    output logic                         fwd_b_hit,
    output logic [XLEN-1:0]              fwd_b,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    logic   space;
    logic   alu_acc;
    logic   lsu_acc;
    logic   push;
    logic   pop;
    entry_t in_entry;

    // Acceptance: ready is a function of the registered count only, so a
    // dequeue in the same cycle never reopens a full queue.
    always_comb begin
        space     = (cnt_q < CW'(DEPTH));
        alu_ready = space;
        lsu_ready = space & ~alu_valid;
        alu_acc   = alu_valid & space;
        lsu_acc   = lsu_valid & space & ~alu_valid;
        in_entry  = alu_valid ? entry_t'{rd: alu_rd, data: alu_data}
                              : entry_t'{rd: lsu_rd, data: lsu_data};
        // Results for x0 complete the handshake but are dropped.
        push      = (alu_acc | lsu_acc) & (in_entry.rd != '0);
    end

    // Drain: head entry drives the write port whenever the queue is non-empty.
    always_comb begin
        enable = (cnt_q != '0) & ~wr_stall;
        pop    = enable;
        rdaddr = '0;
        data   = '0;
        if (cnt_q != '0) begin
            rdaddr = mem[rd_ptr].rd;
            data   = mem[rd_ptr].data;
        end
    end

    // Bypass: walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a_hit = 1'b0;
        fwd_a     = '0;
        fwd_b_hit = 1'b0;
        fwd_b     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q) begin
                if ((rs1addr != '0) && (mem[rd_ptr + PW'(i)].rd == rs1addr)) begin
                    fwd_a_hit = 1'b1;
                    fwd_a     = mem[rd_ptr + PW'(i)].data;
                end
                if ((rs2addr != '0) && (mem[rd_ptr + PW'(i)].rd == rs2addr)) begin
                    fwd_b_hit = 1'b1;
                    fwd_b     = mem[rd_ptr + PW'(i)].data;
                end
            end
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: scenario tasks with a write scoreboard.
module tb_regfile_writeback;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef logic [AW+XLEN-1:0] wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            wr_stall = 1'b0;
    logic [AW-1:0]   rdaddr;
    logic [XLEN-1:0] data;
    logic            enable;
    logic [AW-1:0]   rs1addr = '0;
    logic [AW-1:0]   rs2addr = '0;
    logic            fwd_a_hit;
    logic [XLEN-1:0] fwd_a;
    logic            fwd_b_hit;
    logic [XLEN-1:0] fwd_b;
    logic [CW-1:0]   count;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    regfile_writeback #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wr_stall(wr_stall), .rdaddr(rdaddr), .data(data), .enable(enable),
        .rs1addr(rs1addr), .rs2addr(rs2addr),
        .fwd_a_hit(fwd_a_hit), .fwd_a(fwd_a), .fwd_b_hit(fwd_b_hit), .fwd_b(fwd_b),
        .count(count)
    );

    always #5 clk = ~clk;

    // Record every regfile write the DUT performs (committed at the following posedge).
    always @(negedge clk) begin
        if (enable === 1'b1) obs_q.push_back({rdaddr, data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wr_t e;
        wr_t o;
        rst_n = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (count !== '0 || enable !== 1'b0 || rdaddr !== '0 || data !== '0 ||
            fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got count=%0d en=%b rdaddr=%0d data=%h ha=%b hb=%b rdy=%b want 0/0/0/0/0/0/1",
                     count, enable, rdaddr, data, fwd_a_hit, fwd_b_hit, alu_ready);
        end
        step();
        rst_n = 1'b1;
        // Fill the queue while the write port is stalled, then reset mid-stream.
        wr_stall = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        step();
        alu_rd = 5'd2; alu_data = 32'h200;
        step();
        alu_valid = 1'b0;
        rs1addr = 5'd1; rs2addr = 5'd2;
        @(negedge clk);
        vectors++;
        if (count !== CW'(2) || fwd_a_hit !== 1'b1 || fwd_a !== 32'h100 ||
            fwd_b_hit !== 1'b1 || fwd_b !== 32'h200) begin
            miscompares++;
            $display("FAIL reset_prefill got count=%0d ha=%b a=%h hb=%b b=%h want 2/1/100/1/200",
                     count, fwd_a_hit, fwd_a, fwd_b_hit, fwd_b);
        end
        #1;
        wr_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== '0 || enable !== 1'b0 || fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midstream got count=%0d en=%b ha=%b hb=%b want 0/0/0/0",
                     count, enable, fwd_a_hit, fwd_b_hit);
        end
        step();
        rst_n = 1'b1;
        rs1addr = '0; rs2addr = '0;
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_writes got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (enable !== 1'b1 || rdaddr !== 5'd9 || data !== 32'h99) begin
            miscompares++;
            $display("FAIL reset_first_write got en=%b rd=%0d data=%h want 1/9/99", enable, rdaddr, data);
        end
        step(); step();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL reset_sb extra write got %h want none", obs_q.pop_front());
            end else if (obs_q.size() == 0) begin
                miscompares++; $display("FAIL reset_sb missing write got none want %h", exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin miscompares++; $display("FAIL reset_sb got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_single_alu();
        wr_t e;
        wr_t o;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (enable !== 1'b1 || rdaddr !== 5'd5 || data !== 32'hDEADBEEF || count !== CW'(1)) begin
            miscompares++;
            $display("FAIL single_write got en=%b rd=%0d data=%h cnt=%0d want 1/5/deadbeef/1",
                     enable, rdaddr, data, count);
        end
        step();
        @(negedge clk);
        vectors++;
        if (enable !== 1'b0 || count !== '0) begin
            miscompares++;
            $display("FAIL single_drained got en=%b cnt=%0d want 0/0", enable, count);
        end
        step();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL single_sb extra write got %h want none", obs_q.pop_front());
            end else if (obs_q.size() == 0) begin
                miscompares++; $display("FAIL single_sb missing write got none want %h", exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin miscompares++; $display("FAIL single_sb got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_priority();
        wr_t e;
        wr_t o;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_ready got alu=%b lsu=%b want 1/0", alu_ready, lsu_ready);
        end
        exp_q.push_back({5'd3, 32'h11});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (lsu_ready !== 1'b1 || enable !== 1'b1 || rdaddr !== 5'd3) begin
            miscompares++;
            $display("FAIL prio_lsu_turn got lsu_rdy=%b en=%b rd=%0d want 1/1/3", lsu_ready, enable, rdaddr);
        end
        exp_q.push_back({5'd4, 32'h22});
        step();
        lsu_valid = 1'b0;
        step(); step();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL prio_sb extra write got %h want none", obs_q.pop_front());
            end else if (obs_q.size() == 0) begin
                miscompares++; $display("FAIL prio_sb missing write got none want %h", exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin miscompares++; $display("FAIL prio_sb got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_stall_bypass();
        wr_t e;
        wr_t o;
        wr_stall = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
        exp_q.push_back({5'd7, 32'hA});
        step();
        alu_data = 32'hB;
        exp_q.push_back({5'd7, 32'hB});
        step();
        alu_valid = 1'b0;
        rs1addr = 5'd7; rs2addr = 5'd8;
        @(negedge clk);
        vectors++;
        if (count !== CW'(2) || alu_ready !== 1'b0 || lsu_ready !== 1'b0 || enable !== 1'b0 ||
            fwd_a_hit !== 1'b1 || fwd_a !== 32'hB || fwd_b_hit !== 1'b0 || fwd_b !== '0) begin
            miscompares++;
            $display("FAIL stall_full got cnt=%0d ar=%b lr=%b en=%b ha=%b a=%h hb=%b b=%h want 2/0/0/0/1/b/0/0",
                     count, alu_ready, lsu_ready, enable, fwd_a_hit, fwd_a, fwd_b_hit, fwd_b);
        end
        step();
        // Release the stall while offering a new result: a full queue stays closed this cycle.
        wr_stall = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hC;
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b0 || enable !== 1'b1 || data !== 32'hA) begin
            miscompares++;
            $display("FAIL full_no_passthru got rdy=%b en=%b data=%h want 0/1/a", alu_ready, enable, data);
        end
        step();
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b1 || enable !== 1'b1 || fwd_a_hit !== 1'b1 || fwd_a !== 32'hB || fwd_b_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL head_bypass got rdy=%b en=%b ha=%b a=%h hb=%b want 1/1/1/b/0",
                     alu_ready, enable, fwd_a_hit, fwd_a, fwd_b_hit);
        end
        exp_q.push_back({5'd8, 32'hC});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== CW'(1) || fwd_b_hit !== 1'b1 || fwd_b !== 32'hC || fwd_a_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_c got cnt=%0d hb=%b b=%h ha=%b want 1/1/c/0", count, fwd_b_hit, fwd_b, fwd_a_hit);
        end
        step(); step();
        rs1addr = '0; rs2addr = '0;
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL stall_sb extra write got %h want none", obs_q.pop_front());
            end else if (obs_q.size() == 0) begin
                miscompares++; $display("FAIL stall_sb missing write got none want %h", exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin miscompares++; $display("FAIL stall_sb got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_x0_drop();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        rs2addr = 5'd0;
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_handshake got rdy=%b want 1", alu_ready);
        end
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== '0 || enable !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_b !== '0) begin
            miscompares++;
            $display("FAIL x0_dropped got cnt=%0d en=%b hb=%b b=%h want 0/0/0/0", count, enable, fwd_b_hit, fwd_b);
        end
        step(); step();
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL x0_no_write got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        wr_t o;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
        for (int i = 0; i < 20; i++) begin
            rd = AW'(i % 31 + 1);
            d  = $urandom;
            alu_valid = 1'b1; alu_rd = rd; alu_data = d;
            @(negedge clk);
            vectors++;
            if (alu_ready !== 1'b1 || count > CW'(1) || enable !== (i != 0)) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d got rdy=%b cnt=%0d en=%b want 1/<=1/%b",
                         i, alu_ready, count, enable, (i != 0));
            end
            exp_q.push_back({rd, d});
            step();
        end
        alu_valid = 1'b0;
        step(); step();
        vectors++;
        if (obs_q.size() != 20) begin
            miscompares++;
            $display("FAIL b2b_count got %0d writes want 20", obs_q.size());
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_sb extra write got %h want none", obs_q.pop_front());
            end else if (obs_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_sb missing write got none want %h", exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin miscompares++; $display("FAIL b2b_sb got %h want %h", o, e); end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_alu();
        test_priority();
        test_stall_bypass();
        test_x0_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
